wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter directly upstream of the register file write port. Merges single-cycle pipeline write-backs with results from long-latency units (divider, uncached loads) that finish out of step with the pipeline. Buffers long-latency results in a small FIFO while the pipeline owns the port. Keeps a per-register pending scoreboard so decode can stall on registers whose results have not yet been written.

## Interface

Parameters:
- FIFO_DEPTH, 4: long-latency result buffer entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- pipe_we  in  1  pipeline write-back valid.
- pipe_addr  in  5  pipeline destination register.
- pipe_data  in  32  pipeline result.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  arbiter can accept a long-latency result.
- lu_addr  in  5  long-latency destination register.
- lu_data  in  32  long-latency result.
- issue_valid  in  1  a long-latency op is issued this cycle.
- issue_addr  in  5  its destination register.
- query_addr_1  in  5  decode source register 1.
- query_addr_2  in  5  decode source register 2.
- busy_1  out  1  query_addr_1 has an outstanding long-latency write.
- busy_2  out  1  query_addr_2 has an outstanding long-latency write.
- write_enable  out  1  register file write enable (registered).
- write_addr  out  5  register file write address (registered).
- write_data  out  32  register file write data (registered).

## Operation

- Reset state: write_enable 0, write_addr 0, write_data 0, FIFO empty, all pending bits 0. lu_ready is 1 during and after reset; inputs are ignored while rst is high.
- Reset mid-operation discards FIFO contents and pending bits. A result in flight is lost, and that loss is legal.
- Writes addressed to register 0 are dropped:
  - A pipeline write to register 0 does not occupy the port.
  - A long-latency result to register 0 is accepted (handshake completes) but not queued.
- Accept: a long-latency result is taken when lu_valid && lu_ready. lu_ready = (count < FIFO_DEPTH). It depends only on registered state and never combinationally on a same-cycle pop. lu_data/lu_addr must stay stable while lu_valid && !lu_ready.
- Port arbitration, evaluated each cycle; first match loads the output registers:
  1. pipe_we && pipe_addr != 0: pipeline write.
  2. FIFO non-empty: pop the head.
  3. Bypass path (see Configuration).
  4. Otherwise write_enable <= 0; write_addr and write_data hold their previous values.
- The pipeline always wins the port. A queued entry waits while pipe_we stays high.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit read/write pointers that wrap naturally.
  - Count is (log2(FIFO_DEPTH)+1) bits.
  - Push and pop in the same cycle leave the count unchanged.
  - FIFO order equals acceptance order.
- Scoreboard: 32 pending bits; bit 0 is hardwired 0.
  - Set at the edge where issue_valid && issue_addr != 0.
  - Cleared at the edge where a long-latency entry for that register loads the output registers. In that cycle the register file forwards write_data, so busy drops exactly when the value becomes readable.
  - Same register set and cleared at the same edge: set wins.
- busy_x = pending[query_addr_x]. Combinational; 0 for register 0.
- Decode never issues to, or writes back through the pipeline to, a register that is busy. Behaviour on such a WAW is undefined.

## Timing

- Pipeline write at cycle N: on write_* in cycle N+1, committed into the register file at the end of N+1.
- Long-latency result accepted at N, pipeline idle: on write_* in N+2; busy clears in N+2.
  - Each cycle pipe_we is high delays this by one cycle.
  - With bypass compiled in and the bypass conditions met: N+1.
- Throughput: one register file write per cycle. A full FIFO drains in FIFO_DEPTH idle cycles.
- busy_x has zero latency from query_addr_x and one-cycle latency from issue_valid.

## Configuration

- WB_ARB_BYPASS_EN defined: a long-latency result accepted at cycle N loads the output registers directly, without entering the FIFO, when all of these hold:
  - the FIFO is empty at N;
  - !(pipe_we && pipe_addr != 0) at N.
- The bypassed result then appears on write_* at N+1, and its pending bit clears at the same edge.
- Not defined: every accepted result enters the FIFO; minimum latency is 2 cycles.

## Test plan

- Reset and basic pipeline write:
  - Assert rst 2 cycles: write_enable=0, write_addr=0, write_data=0, lu_ready=1.
  - Then pipe_we=1, pipe_addr=5, pipe_data=0x1234 at N: write_enable=1, addr 5, data 0x1234 at N+1.
  - pipe_addr=0: write_enable stays 0.
- Priority and order:
  - Hold pipe_we=1 for 6 cycles while pushing lu results r3=0xA, r4=0xB, r7=0xC, r9=0xD: lu_ready drops after the 4th accept.
  - After pipe_we falls, write_* emits r3, r4, r7, r9 on 4 consecutive cycles.
  - lu_ready returns to 1 the cycle after the first pop.
- Scoreboard:
  - issue_valid at N for r8: busy(r8)=1 from N+1.
  - lu result r8=0x55 accepted at M with the pipeline idle: busy(r8) falls at the cycle write_addr=8, write_data=0x55 (M+2, or M+1 with WB_ARB_BYPASS_EN).
  - Issue r8 again at the clear edge: busy stays 1.
- Wrap-around: stream 3×FIFO_DEPTH results with alternating pipe_we stalls; the output sequence matches the input order exactly, with no loss or duplication.
- Reset mid-operation: FIFO holding 3 entries, r2 and r6 pending, assert rst 1 cycle.
  - Afterwards busy=0 for all registers.
  - No queued entry is ever written.
  - lu_ready=1.
- Register 0: lu result to r0 accepted (handshake completes), never appears on write_*, FIFO count unchanged. issue to r0 leaves busy(r0)=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline write-backs and buffered long-latency results
// onto the single register file write port, and keeps a per-register
// pending scoreboard so decode can stall on outstanding long-latency writes.
// Optional feature: define WB_ARB_BYPASS_EN to let a long-latency result
// skip the FIFO when the FIFO is empty and the pipeline is not writing.
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  query_addr_1,
    input  logic [4:0]  query_addr_2,
    output logic        busy_1,
    output logic        busy_2,
    output logic        write_enable,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t         fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [31:0]       pending_q, pending_d;
    logic              write_enable_q, write_enable_d;
    logic [4:0]        write_addr_q, write_addr_d;
    logic [31:0]       write_data_q, write_data_d;

    logic              pipe_go;
    logic              lu_accept;
    logic              lu_keep;
    logic              fifo_empty;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              clr_valid;
    logic [4:0]        clr_addr;
    wb_entry_t         head;

    // lu_ready looks only at registered state, and is forced high in reset.
    assign lu_ready   = rst || (count_q < DEPTH_C);
    assign lu_accept  = lu_valid && lu_ready && !rst;
    // A result for register 0 completes its handshake but is never stored.
    assign lu_keep    = lu_accept && (lu_addr != 5'd0);
    assign pipe_go    = pipe_we && (pipe_addr != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_mem_q[rd_ptr_q];

`ifdef WB_ARB_BYPASS_EN
    assign bypass = lu_keep && fifo_empty && !pipe_go;
`else
    assign bypass = 1'b0;
`endif

    assign push = lu_keep && !bypass;
    assign pop  = !pipe_go && !fifo_empty;

    // Next-state for FIFO bookkeeping, port arbitration and scoreboard.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        write_enable_d = 1'b0;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        clr_valid      = 1'b0;
        clr_addr       = 5'd0;
        pending_d      = pending_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Pipeline first, then the queued head, then a bypassed result.
        if (pipe_go) begin
            write_enable_d = 1'b1;
            write_addr_d   = pipe_addr;
            write_data_d   = pipe_data;
        end else if (!fifo_empty) begin
            write_enable_d = 1'b1;
            write_addr_d   = head.addr;
            write_data_d   = head.data;
            clr_valid      = 1'b1;
            clr_addr       = head.addr;
        end else if (bypass) begin
            write_enable_d = 1'b1;
            write_addr_d   = lu_addr;
            write_data_d   = lu_data;
            clr_valid      = 1'b1;
            clr_addr       = lu_addr;
        end

        // Clear before set so a same-edge re-issue keeps the register busy.
        if (clr_valid) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (issue_valid && (issue_addr != 5'd0)) begin
            pending_d[issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Control state and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            pending_q      <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= 5'd0;
            write_data_q   <= 32'd0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            pending_q      <= pending_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
        end
    end

    // FIFO storage writes on push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= '{addr: lu_addr, data: lu_data};
        end
    end

    assign busy_1       = pending_q[query_addr_1];
    assign busy_2       = pending_q[query_addr_2];
    assign write_enable = write_enable_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;

    localparam int FIFO_DEPTH = 4;
`ifdef WB_ARB_BYPASS_EN
    localparam int LU_LAT = 1;
`else
    localparam int LU_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  query_addr_1;
    logic [4:0]  query_addr_2;
    logic        busy_1;
    logic        busy_2;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int n_tests = 0;
    int n_fail  = 0;

    wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_addr    (pipe_addr),
        .pipe_data    (pipe_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_addr      (lu_addr),
        .lu_data      (lu_data),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .query_addr_1 (query_addr_1),
        .query_addr_2 (query_addr_2),
        .busy_1       (busy_1),
        .busy_2       (busy_2),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we     = 1'b0;
        pipe_addr   = 5'd0;
        pipe_data   = 32'd0;
        lu_valid    = 1'b0;
        lu_addr     = 5'd0;
        lu_data     = 32'd0;
        issue_valid = 1'b0;
        issue_addr  = 5'd0;
    endtask

    // Issue r8, deliver its result, optionally re-issue r8 at the clear edge.
    task automatic run_r8(input bit reissue, input logic [31:0] val);
        query_addr_1 = 5'd8;
        query_addr_2 = 5'd8;
        issue_valid  = 1'b1;
        issue_addr   = 5'd8;
        #1;
        check("sb_busy_before_issue", busy_1, 0);
        tick();
        issue_valid = 1'b0;
        check("sb_busy_after_issue", busy_1, 1);
        check("sb_busy2_after_issue", busy_2, 1);
        tick();
        lu_valid = 1'b1;
        lu_addr  = 5'd8;
        lu_data  = val;
        if (LU_LAT == 1 && reissue) begin
            issue_valid = 1'b1;
        end
        tick();
        lu_valid    = 1'b0;
        issue_valid = 1'b0;
        if (LU_LAT == 2) begin
            check("sb_busy_wait", busy_1, 1);
            check("sb_we_wait", write_enable, 0);
            if (reissue) begin
                issue_valid = 1'b1;
            end
            tick();
            issue_valid = 1'b0;
        end
        check("sb_we", write_enable, 1);
        check("sb_addr", write_addr, 8);
        check("sb_data", write_data, val);
        check(reissue ? "sb_busy_reissue" : "sb_busy_clear", busy_1, {31'd0, reissue});
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    initial begin
        logic [4:0]  pri_addr [4];
        logic [31:0] pri_data [4];
        exp_t        expq [$];
        exp_t        e;
        int          k;
        int          received;
        int          extra;
        int          cyc;
        int          nwrites;
        logic [31:0] busy_mask;

        pri_addr = '{5'd3, 5'd4, 5'd7, 5'd9};
        pri_data = '{32'hA, 32'hB, 32'hC, 32'hD};

        // Reset held two cycles.
        idle_inputs();
        query_addr_1 = 5'd0;
        query_addr_2 = 5'd0;
        rst = 1'b1;
        tick();
        check("rst_lu_ready_during", lu_ready, 1);
        tick();
        check("rst_we", write_enable, 0);
        check("rst_addr", write_addr, 0);
        check("rst_data", write_data, 0);
        rst = 1'b0;
        #1;
        check("rst_lu_ready", lu_ready, 1);

        // Basic pipeline write, then a dropped write to r0.
        pipe_we   = 1'b1;
        pipe_addr = 5'd5;
        pipe_data = 32'h1234;
        tick();
        check("pipe_we", write_enable, 1);
        check("pipe_addr", write_addr, 5);
        check("pipe_data", write_data, 32'h1234);
        pipe_addr = 5'd0;
        pipe_data = 32'hFFFF;
        tick();
        check("pipe_r0_we", write_enable, 0);
        check("pipe_r0_addr_hold", write_addr, 5);
        check("pipe_r0_data_hold", write_data, 32'h1234);

        // Pipeline holds the port while four results queue up.
        for (int i = 0; i < 6; i++) begin
            pipe_we   = 1'b1;
            pipe_addr = 5'd1;
            pipe_data = 32'h100 + i;
            lu_valid  = (i < 4);
            lu_addr   = (i < 4) ? pri_addr[i] : 5'd0;
            lu_data   = (i < 4) ? pri_data[i] : 32'd0;
            #1;
            check("pri_lu_ready", lu_ready, (i < 4) ? 1 : 0);
            tick();
            check("pri_pipe_addr", write_addr, 1);
            check("pri_pipe_data", write_data, 32'h100 + i);
        end
        idle_inputs();
        #1;
        check("pri_full_lu_ready", lu_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pri_drain_we", write_enable, 1);
            check("pri_drain_addr", write_addr, pri_addr[i]);
            check("pri_drain_data", write_data, pri_data[i]);
            if (i == 0) begin
                check("pri_lu_ready_back", lu_ready, 1);
            end
        end
        tick();
        check("pri_drain_done", write_enable, 0);

        // Scoreboard: plain clear, then re-issue at the clear edge.
        run_r8(1'b0, 32'h55);
        tick();
        run_r8(1'b1, 32'h55);
        lu_valid = 1'b1;
        lu_addr  = 5'd8;
        lu_data  = 32'h56;
        tick();
        idle_inputs();
        tick();
        tick();
        check("sb_final_clear", busy_1, 0);

        // Wrap-around: 3*FIFO_DEPTH results with alternating pipeline stalls.
        k        = 0;
        received = 0;
        extra    = 0;
        cyc      = 0;
        while ((k < 3 * FIFO_DEPTH || received < 3 * FIFO_DEPTH) && cyc < 300) begin
            pipe_we   = cyc[0];
            pipe_addr = 5'd1;
            pipe_data = 32'hBEEF;
            lu_valid  = (k < 3 * FIFO_DEPTH);
            lu_addr   = 5'(2 + k);
            lu_data   = 32'hC000 + k;
            #1;
            if (lu_valid && lu_ready) begin
                e.addr = lu_addr;
                e.data = lu_data;
                expq.push_back(e);
                k++;
            end
            tick();
            cyc++;
            if (write_enable && write_addr != 5'd1) begin
                if (expq.size() == 0) begin
                    extra++;
                end else begin
                    e = expq.pop_front();
                    check("wrap_addr", write_addr, e.addr);
                    check("wrap_data", write_data, e.data);
                    received++;
                end
            end
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (write_enable) extra++;
        end
        check("wrap_count", received, 3 * FIFO_DEPTH);
        check("wrap_extra", extra, 0);

        // Reset mid-operation: three queued entries, r2 and r6 pending.
        issue_valid = 1'b1;
        issue_addr  = 5'd2;
        tick();
        issue_addr  = 5'd6;
        tick();
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pipe_we   = 1'b1;
            pipe_addr = 5'd1;
            pipe_data = 32'h77;
            lu_valid  = 1'b1;
            lu_addr   = (i == 0) ? 5'd2 : (i == 1) ? 5'd6 : 5'd11;
            lu_data   = 32'hE0 + i;
            tick();
        end
        query_addr_1 = 5'd2;
        query_addr_2 = 5'd6;
        #1;
        check("mid_busy_r2_before", busy_1, 1);
        check("mid_busy_r6_before", busy_2, 1);
        rst         = 1'b1;
        issue_valid = 1'b1;
        issue_addr  = 5'd13;
        lu_addr     = 5'd12;
        #1;
        check("mid_lu_ready_in_rst", lu_ready, 1);
        tick();
        rst = 1'b0;
        idle_inputs();
        check("mid_we_after_rst", write_enable, 0);
        check("mid_lu_ready", lu_ready, 1);
        busy_mask = '0;
        for (int r = 0; r < 32; r++) begin
            query_addr_1 = 5'(r);
            #1;
            busy_mask[r] = busy_1;
        end
        check("mid_busy_mask", busy_mask, 0);
        nwrites = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (write_enable) nwrites++;
        end
        check("mid_no_writes", nwrites, 0);

        // Register 0: accepted, never written, does not occupy the FIFO.
        lu_valid     = 1'b1;
        lu_addr      = 5'd0;
        lu_data      = 32'hDEAD;
        issue_valid  = 1'b1;
        issue_addr   = 5'd0;
        query_addr_2 = 5'd0;
        #1;
        check("r0_lu_ready", lu_ready, 1);
        tick();
        idle_inputs();
        check("r0_busy", busy_2, 0);
        nwrites = 0;
        for (int i = 0; i < 3; i++) begin
            if (write_enable) nwrites++;
            tick();
        end
        check("r0_no_write", nwrites, 0);
        for (int i = 0; i < 5; i++) begin
            pipe_we   = 1'b1;
            pipe_addr = 5'd1;
            pipe_data = 32'h0;
            lu_valid  = (i < 4);
            lu_addr   = 5'd20;
            lu_data   = 32'h200 + i;
            #1;
            check("r0_fill_lu_ready", lu_ready, (i < 4) ? 1 : 0);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check("r0_drained_lu_ready", lu_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
